alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand and result width.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports reqN_valid  input  1  requester N (N=0,1) operation valid.
REQ-005 The block SHALL have ports reqN_ready  output  1  requester N accepted this cycle when valid&ready.
REQ-006 The block SHALL have ports reqN_op  input  4  requester N ALU opcode.
REQ-007 The block SHALL have ports reqN_a, reqN_b  input  DATA_W  requester N operands.
REQ-008 The block SHALL have port rsp_valid  output  1  response valid.
REQ-009 The block SHALL have port rsp_ready  input  1  response consumed when valid&ready.
REQ-010 The block SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-011 The block SHALL have port rsp_result  output  DATA_W  operation result.
REQ-012 The block SHALL have ports rsp_zero and rsp_err  output  1 each  result-is-zero flag; unsupported-opcode flag.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC, RESP; one transaction in flight at most.
REQ-014 In IDLE, reqN_ready SHALL be asserted only for the granted requester, and only when its reqN_valid is high; in EXEC and RESP both readies SHALL be 0.
REQ-015 On handshake, op/a/b and grant index SHALL be latched and the state SHALL move IDLE->EXEC.
REQ-016 In EXEC the latched operands SHALL drive the ALU core; result, zero and err SHALL be registered and the state SHALL move to RESP after exactly one cycle.
REQ-017 rsp_valid SHALL be high in RESP only; response fields SHALL be stable while rsp_valid&!rsp_ready.
REQ-018 On rsp_valid&rsp_ready the state SHALL return to IDLE; a new grant SHALL be possible the cycle after (accept-to-response latency 2 cycles, throughput one op per 3 cycles minimum).
REQ-019 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (two's complement, wraps modulo 2^DATA_W), 0111 SLT unsigned (1/0), 1100 NOR.
REQ-020 Any other opcode SHALL yield rsp_result=0, rsp_zero=1, rsp_err=1; rsp_err SHALL be 0 for supported opcodes.
REQ-021 rsp_zero SHALL equal (rsp_result==0) for every response.
REQ-022 Arbitration SHALL be round-robin: when both valid in IDLE, grant the requester not granted last; a single valid requester SHALL be granted regardless of pointer.
REQ-023 The last-grant pointer SHALL update only on an accepted handshake.
REQ-024 Requests not granted SHALL wait; a requester may drop valid before acceptance without effect.

Reset
REQ-025 On rst_n low: state IDLE, req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, last-grant pointer=1 (so requester 0 wins first contention).
REQ-026 Reset asserted mid-transaction SHALL discard the in-flight operation with no response produced.

Configuration
REQ-027 With ALU_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (requester 0 always wins contention) and the pointer SHALL be absent; without it, REQ-022/023 apply.

Structure
REQ-028 A shared package SHALL hold the 4-bit opcode constants, the FSM state enum and DATA_W default.
REQ-029 The combinational operation SHALL live in one sub-module alu_core (A, B, op -> result, zero, err), instantiated once.

Verification
REQ-030 req0 valid, op=0010, a=5, b=7 -> req0_ready 1 cycle, rsp_valid 2 cycles later, rsp_id=0, result=12, zero=0, err=0.
REQ-031 Both valid from reset, op=0110, a=3, b=3 each -> req0 served first (result 0, zero=1), then req1 (rsp_id=1); with ALU_ARB_FIXED_PRIO_EN and req0 held continuously, req1 never granted.
REQ-032 op=0110, a=0, b=1 -> result=0xFFFFFFFF; op=0111, a=0xFFFFFFFF, b=1 -> result=0 (unsigned).
REQ-033 op=1111 -> result=0, zero=1, err=1; rsp_ready held low 5 cycles -> fields stable, no new grant.
REQ-034 rst_n pulsed low during EXEC -> rsp_valid stays 0, all outputs at reset values, next request served normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants, FSM state encoding and default datapath width
// for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational ALU: a, b, op -> result, zero, err. No state, no handshake.
// Unsupported opcodes give a zero result with err set.
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_SLT: result[0] = (a < b);
            OP_NOR: result = ~(a | b);
            default: begin
                result = '0;
                err    = 1'b1;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter: accept -> EXEC -> RESP, response 2 cycles after accept, holds in RESP until rsp_ready.
// Round-robin by default; ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins) with no pointer.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err
);

    state_t            state;
    state_t            state_nxt;
    logic              gnt;
    logic              hs;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] core_result;
    logic              core_zero;
    logic              core_err;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign gnt = !req0_valid;
`else
    logic last_q;

    // Contention goes to whoever was not served last; a lone requester always wins.
    assign gnt = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (hs) begin
            last_q <= gnt;
        end
    end
`endif

    // Readies are forced low while reset is held even if a requester is valid.
    assign req0_ready = rst_n && (state == IDLE) && !gnt && req0_valid;
    assign req1_ready = rst_n && (state == IDLE) &&  gnt && req1_valid;
    assign hs         = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rsp_id <= 1'b0;
        end else if (hs) begin
            op_q   <= gnt ? req1_op : req0_op;
            a_q    <= gnt ? req1_a  : req0_a;
            b_q    <= gnt ? req1_b  : req0_b;
            rsp_id <= gnt;
        end
    end

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (core_result),
        .zero   (core_zero),
        .err    (core_err)
    );

    // Response fields load only in EXEC, so they stay frozen through a stalled RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_result <= core_result;
            rsp_zero   <= core_zero;
            rsp_err    <= core_err;
        end
    end

    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed literal cases plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    vld = 2'b00;
    logic [3:0]    op [2];
    logic [W-1:0]  a [2];
    logic [W-1:0]  b [2];
    logic          rdy0, rdy1;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id, rsp_zero, rsp_err;
    logic [W-1:0]  rsp_result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (vld[0]),
        .req0_ready (rdy0),
        .req0_op    (op[0]),
        .req0_a     (a[0]),
        .req0_b     (b[0]),
        .req1_valid (vld[1]),
        .req1_ready (rdy1),
        .req1_op    (op[1]),
        .req1_a     (a[1]),
        .req1_b     (b[1]),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           stage = 0;       // 0 idle, 1 executing, 2 response pending
    bit           last  = 1'b1;
    logic         m_id;
    logic [W-1:0] m_res;
    logic         m_zero, m_err;

    function automatic void model_alu(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] r, output logic e);
        e = 1'b0;
        case (o)
            4'd0:    r = x & y;
            4'd1:    r = x | y;
            4'd2:    r = x + y;
            4'd6:    r = x - y;
            4'd7:    r = (x < y) ? 1 : 0;
            4'd12:   r = ~(x | y);
            default: begin r = 0; e = 1'b1; end
        endcase
    endfunction

    function automatic bit pick(input bit v0, input bit v1, input bit lst);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return !v0;
`else
        if (v0 && v1) return !lst;
        return v1;
`endif
    endfunction

    always @(negedge clk) begin
        bit g, e0, e1;
        if (!rst_n) begin
            chk("rst_req0_ready", rdy0, 0);
            chk("rst_req1_ready", rdy1, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_zero", rsp_zero, 0);
            chk("rst_rsp_err", rsp_err, 0);
            stage  = 0;
            last   = 1'b1;
            m_id   = 1'b0;
            m_res  = '0;
            m_zero = 1'b0;
            m_err  = 1'b0;
        end else begin
            g  = pick(vld[0], vld[1], last);
            e0 = (stage == 0) && vld[0] && !g;
            e1 = (stage == 0) && vld[1] && g;
            chk("m_req0_ready", rdy0, e0);
            chk("m_req1_ready", rdy1, e1);
            chk("m_rsp_valid", rsp_valid, (stage == 2));
            if (stage == 2) begin
                chk("m_rsp_id", rsp_id, m_id);
                chk("m_rsp_result", rsp_result, m_res);
                chk("m_rsp_zero", rsp_zero, m_zero);
                chk("m_rsp_err", rsp_err, m_err);
            end
            if (stage == 0 && (e0 || e1)) begin
                model_alu(op[g], a[g], b[g], m_res, m_err);
                m_zero = (m_res == 0);
                m_id   = g;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last   = g;
`endif
                stage  = 1;
            end else if (stage == 1) begin
                stage = 2;
            end else if (stage == 2 && rsp_ready) begin
                stage = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        step();
        vld   = 2'b00;
        rst_n = 1'b0;
        at_neg();
        chk("pulse_rsp_valid", rsp_valid, 0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic txn(input int id, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ez, input logic ee, input int hold);
        step();
        vld       = 2'b00;
        vld[id]   = 1'b1;
        op[id]    = o;
        a[id]     = x;
        b[id]     = y;
        rsp_ready = (hold == 0);
        at_neg();
        chk("t_ready_own", (id == 0) ? rdy0 : rdy1, 1);
        chk("t_ready_other", (id == 0) ? rdy1 : rdy0, 0);
        step();
        vld = 2'b00;
        at_neg();
        chk("t_exec_rsp_valid", rsp_valid, 0);
        step();
        if (hold > 0) vld = 2'b11;
        at_neg();
        chk("t_rsp_valid", rsp_valid, 1);
        chk("t_rsp_id", rsp_id, id);
        chk("t_rsp_result", rsp_result, er);
        chk("t_rsp_zero", rsp_zero, ez);
        chk("t_rsp_err", rsp_err, ee);
        if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                step();
                at_neg();
                chk("t_hold_valid", rsp_valid, 1);
                chk("t_hold_result", rsp_result, er);
                chk("t_hold_err", rsp_err, ee);
                chk("t_hold_no_grant", rdy0 | rdy1, 0);
            end
            step();
            rsp_ready = 1'b1;
            at_neg();
            chk("t_hold_last_valid", rsp_valid, 1);
        end
        step();
        vld = 2'b00;
        at_neg();
        chk("t_done_rsp_valid", rsp_valid, 0);
    endtask

    function automatic logic [3:0] rand_op();
        int k = $urandom_range(0, 7);
        case (k)
            0: return 4'd0;
            1: return 4'd1;
            2: return 4'd2;
            3: return 4'd6;
            4: return 4'd7;
            5: return 4'd12;
            default: return 4'($urandom);
        endcase
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        int k = $urandom_range(0, 3);
        if (k == 0) return W'($urandom_range(0, 3));
        if (k == 1) return {W{1'b1}} - W'($urandom_range(0, 3));
        return W'($urandom);
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            op[i] = 4'd0;
            a[i]  = '0;
            b[i]  = '0;
        end
        at_neg();
        step();
        rst_n = 1'b1;

        // single request, ADD 5+7
        txn(0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 0);

        // contention straight out of reset
        reset_pulse();
        step();
        vld = 2'b11;
        op[0] = 4'b0110; a[0] = 32'd3; b[0] = 32'd3;
        op[1] = 4'b0110; a[1] = 32'd3; b[1] = 32'd3;
        rsp_ready = 1'b1;
        at_neg();
        chk("c_first_r0", rdy0, 1);
        chk("c_first_r1", rdy1, 0);
        step();
        at_neg();
        chk("c_exec_readies", rdy0 | rdy1, 0);
        step();
        at_neg();
        chk("c_rsp0_valid", rsp_valid, 1);
        chk("c_rsp0_id", rsp_id, 0);
        chk("c_rsp0_result", rsp_result, 0);
        chk("c_rsp0_zero", rsp_zero, 1);
        step();
        at_neg();
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("c_second_r0", rdy0, 1);
        chk("c_second_r1", rdy1, 0);
`else
        chk("c_second_r0", rdy0, 0);
        chk("c_second_r1", rdy1, 1);
`endif
        step();
        vld = 2'b00;
        step();
        at_neg();
        chk("c_rsp1_valid", rsp_valid, 1);
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("c_rsp1_id", rsp_id, 0);
`else
        chk("c_rsp1_id", rsp_id, 1);
`endif
        step();

        // wrap and unsigned compare corners
        txn(1, 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        txn(0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 0);
        txn(1, 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);
        // unsupported opcode with a stalled response
        txn(0, 4'b1111, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 5);

        // reset while executing drops the operation
        step();
        vld = 2'b01; op[0] = 4'b0010; a[0] = 32'd1; b[0] = 32'd1;
        rsp_ready = 1'b1;
        step();
        vld   = 2'b00;
        rst_n = 1'b0;
        at_neg();
        chk("r_rsp_valid", rsp_valid, 0);
        chk("r_rsp_result", rsp_result, 0);
        step();
        rst_n = 1'b1;
        at_neg();
        chk("r_after_valid", rsp_valid, 0);
        step();
        at_neg();
        chk("r_no_late_rsp", rsp_valid, 0);
        txn(1, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 0);

        // randomized traffic
        repeat (3000) begin
            step();
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 9) < 6);
                op[i]  = rand_op();
                a[i]   = rand_opnd();
                b[i]   = ($urandom_range(0, 5) == 0) ? a[i] : rand_opnd();
            end
            rsp_ready = ($urandom_range(0, 9) < 6);
        end
        step();
        vld       = 2'b00;
        rsp_ready = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
